manchester_deserializer: RTL and testbench
==========================================

# manchester_deserializer

Receive-side counterpart of the Manchester serializer. It oversamples a single-wire Manchester line, recovers framed bytes and presents them on an AXI-Stream master port through a 4-entry FIFO. It sits between the board-level serial input and any AXI-Stream byte consumer. Code violations and FIFO overflow are reported on status outputs.

## Interface
- HALF_BIT, 4: aclk cycles per Manchester half-bit; legal values are 2..255.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, at least 2.
- aclk  in  1  single clock; all logic is rising-edge.
- aresetn  in  1  asynchronous, active-low reset.
- serial_in  in  1  Manchester line input.
- m_axis_tvalid  out  1  byte available.
- m_axis_tready  in  1  consumer accepts the byte.
- m_axis_tdata  out  8  received byte.
- frame_err  out  1  one-cycle pulse on a code violation.
- overflow  out  1  sticky; set when a byte is dropped; cleared only by reset.
- rx_busy  out  1  high while a frame is being received.

## Operation
- Line format (shared with the serializer):
  - Idle is low.
  - Bit '1' = low then high; bit '0' = high then low.
  - A frame is one start bit '0' followed by 8 data bits, MSB first.
  - Minimum inter-frame idle is one bit time (2*HALF_BIT cycles) low.
- State machine: IDLE, START, DATA.
- IDLE
  - An arm flag sets once the line has been sampled low for HALF_BIT consecutive cycles.
  - While armed, a sampled 0->1 transition (edge cycle t) enters START and clears the half-bit counter.
- Sample points: at t + HALF_BIT/2 + k*HALF_BIT for k = 0..17 (integer division).
- START
  - k=0 must sample high. If it samples low, this is a false start: return to IDLE with no frame_err.
  - k=1 must sample low. If it samples high, this is a violation.
  - Otherwise enter DATA.
- DATA
  - Each pair (k=2n+2, k=2n+3) is decoded: 01 -> 1, 10 -> 0.
  - 00 or 11 is a violation: pulse frame_err for one cycle, discard the partial byte, return to IDLE with arm cleared.
  - After the 8th pair the byte is pushed into the FIFO and the state returns to IDLE with arm cleared.
- FIFO push when full: drop the byte and set overflow. A FIFO pop occurring in the same cycle frees a slot first, so the push succeeds.
- AXI-Stream master rules:
  - m_axis_tdata = FIFO head.
  - m_axis_tvalid = FIFO not empty.
  - Pop on tvalid && tready.
  - tdata is stable while tvalid is high and tready is low.
  - tvalid never depends combinationally on tready.
- rx_busy is high in START and DATA.
- Reset values (also apply on reset mid-frame): state IDLE, arm 0, FIFO empty, m_axis_tvalid 0, m_axis_tdata 0x00, frame_err 0, overflow 0, rx_busy 0. A partial frame is lost, and receive re-arms only after HALF_BIT low samples.

## Timing
- Sampled line = serial_in registered once, or 3 flops when the synchronizer is enabled.
- Last sample (k=17) at cycle s: FIFO write at the s edge, m_axis_tvalid high at s+1 if the FIFO was empty.
- Latency from the start edge to tvalid: HALF_BIT/2 + 17*HALF_BIT + 1 cycles, plus synchronizer delay.
- frame_err is high for exactly one cycle, the cycle after the violating sample.
- The FIFO sustains one pop per cycle. Back-to-back frames need no tready gaps.

## Configuration
- MANCHESTER_DESER_SYNC_EN defined:
  - serial_in passes through a 2-flop synchronizer before the sampling register.
  - Adds 2 cycles to every latency figure.
- Not defined: serial_in is assumed synchronous to aclk and uses a single sampling register.

## Structure
- Shared package manchester_pkg holds:
  - the rx state enum (IDLE, START, DATA);
  - the encoding constants MANCH_ONE=2'b01 and MANCH_ZERO=2'b10;
  - FRAME_DATA_BITS=8 and the idle level.
- The serializer uses the same package.
- One sub-module, manchester_rx_fifo: synchronous FIFO with push/pop/full/empty and same-cycle push+pop support.

## Test plan
- HALF_BIT=4, tready=1, frames 0xF0, 0x0F, 0xAA with 8-cycle idle between them -> three beats 0xF0, 0x0F, 0xAA in order; frame_err never asserted.
- Frame 0xA5 whose 3rd data bit is driven as 11 -> one frame_err pulse, no beat emitted; the following frame 0x3C is received correctly.
- tready=0, five frames 0x01..0x05 -> FIFO holds 0x01..0x04, overflow=1 after frame 5; releasing tready -> beats 0x01..0x04 only.
- A 1-cycle high glitch on an idle line -> false start, no beat, no frame_err, rx_busy drops within HALF_BIT cycles.
- aresetn asserted during bit 4 of frame 0x55 -> all outputs at reset values immediately; the next full frame 0x99 is received as 0x99.
- tready toggling every cycle over 4 queued bytes -> tdata stable while stalled, each byte seen exactly once.

Source files
------------

// File: rtl/manchester_pkg.sv
// Definitions shared by the Manchester serializer and deserializer: rx states,
// line encoding constants and frame geometry.
package manchester_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } rx_state_t;

    localparam logic [1:0] MANCH_ONE       = 2'b01;
    localparam logic [1:0] MANCH_ZERO      = 2'b10;
    localparam int         FRAME_DATA_BITS = 8;
    localparam logic       IDLE_LEVEL      = 1'b0;

    // Start bit plus data bits, two half-bit samples each; this is the last sample index.
    localparam int LAST_SAMPLE = 2 * FRAME_DATA_BITS + 1;

    function automatic logic manch_valid(input logic [1:0] sym);
        return (sym == MANCH_ONE) || (sym == MANCH_ZERO);
    endfunction

endpackage

// File: rtl/manchester_rx_fifo.sv
// Small synchronous FIFO for received bytes; a pop in the same cycle as a push
// into a full FIFO frees the slot, so the push is accepted.
module manchester_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: the storage is reset because the head entry drives tdata directly and
    // must read 0x00 out of reset; at this depth the extra reset fan-out is trivial.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/manchester_deserializer.sv
// Oversampling Manchester receiver: decodes start + 8 data bit frames into an AXI-Stream
// byte FIFO. Define MANCHESTER_DESER_SYNC_EN to insert a 2-flop input synchronizer.
module manchester_deserializer
    import manchester_pkg::*;
#(
    parameter int HALF_BIT   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       serial_in,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       frame_err,
    output logic       overflow,
    output logic       rx_busy
);
    localparam logic [7:0] HB_CNT    = 8'(HALF_BIT);
    localparam logic [7:0] SAMPLE_PH = 8'(HALF_BIT / 2);
    localparam logic [4:0] LAST_K    = 5'(LAST_SAMPLE);

    rx_state_t                  state, state_nx;
    logic                       line_s;
    logic [7:0]                 phase, low_cnt;
    logic [4:0]                 k_idx;
    logic                       first_half;
    logic [FRAME_DATA_BITS-1:0] shreg, push_data;
    logic [1:0]                 pair;
    logic                       armed, sample_hit, dec_bit;
    logic                       push, violation, pop, fifo_full, fifo_empty;

`ifdef MANCHESTER_DESER_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            sync_q <= {2{IDLE_LEVEL}};
            line_s <= IDLE_LEVEL;
        end else begin
            sync_q <= {sync_q[0], serial_in};
            line_s <= sync_q[1];
        end
    end
`else
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) line_s <= IDLE_LEVEL;
        else          line_s <= serial_in;
    end
`endif

    // phase counts cycles since the start edge modulo HALF_BIT; mid-half samples land on SAMPLE_PH.
    assign armed      = (low_cnt == HB_CNT);
    assign sample_hit = (phase == SAMPLE_PH);
    assign pair       = {first_half, line_s};
    assign dec_bit    = (pair == MANCH_ONE);
    assign push_data  = {shreg[FRAME_DATA_BITS-2:0], dec_bit};
    assign pop        = m_axis_tvalid && m_axis_tready;
    assign rx_busy    = (state != IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_nx  = state;
        push      = 1'b0;
        violation = 1'b0;
        unique case (state)
            IDLE: begin
                if (armed && line_s != IDLE_LEVEL) state_nx = START;
            end
            START: begin
                if (sample_hit) begin
                    if (k_idx == 5'd0) begin
                        if (line_s == IDLE_LEVEL) state_nx = IDLE;
                    end else if (line_s != IDLE_LEVEL) begin
                        violation = 1'b1;
                        state_nx  = IDLE;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                if (sample_hit && k_idx[0]) begin
                    if (!manch_valid(pair)) begin
                        violation = 1'b1;
                        state_nx  = IDLE;
                    end else if (k_idx == LAST_K) begin
                        push     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            phase      <= '0;
            k_idx      <= '0;
            low_cnt    <= '0;
            first_half <= 1'b0;
            shreg      <= '0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_err <= violation;
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (state == IDLE) begin
                // Loading 1 here makes phase equal the cycle offset from the start edge.
                phase <= 8'd1;
                k_idx <= '0;
                if (line_s != IDLE_LEVEL) low_cnt <= '0;
                else if (!armed)          low_cnt <= low_cnt + 8'd1;
            end else begin
                phase <= (phase == HB_CNT - 8'd1) ? 8'd0 : phase + 8'd1;
                if (sample_hit) begin
                    k_idx      <= k_idx + 5'd1;
                    first_half <= line_s;
                    if (state == DATA && k_idx[0]) shreg <= push_data;
                end
            end
        end
    end

    manchester_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_DATA_BITS)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .din     (push_data),
        .pop     (pop),
        .dout    (m_axis_tdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign m_axis_tvalid = !fifo_empty;

endmodule

// File: tb/tb_manchester_deserializer.sv
// Self-checking bench for manchester_deserializer: directed vector table, multi-cycle
// corner sequences and randomized frames against a queue-based reference model.
module tb_manchester_deserializer;

    localparam int HALF_BIT   = 4;
    localparam int FIFO_DEPTH = 4;
`ifdef MANCHESTER_DESER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Cycles from driving the start edge to tvalid: input register + mid-sample + 17 half-bits + FIFO write.
    localparam int LATENCY = 1 + HALF_BIT / 2 + 17 * HALF_BIT + 1 + SYNC_LAT;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       serial_in = 1'b0;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       frame_err;
    logic       overflow;
    logic       rx_busy;

    manchester_deserializer #(
        .HALF_BIT   (HALF_BIT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .serial_in     (serial_in),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .frame_err     (frame_err),
        .overflow      (overflow),
        .rx_busy       (rx_busy)
    );

    initial forever #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // tready driver: held level, toggling, or random per cycle.
    typedef enum int {RDY_HOLD, RDY_TOGGLE, RDY_RANDOM} rdy_mode_t;
    rdy_mode_t rdy_mode = RDY_HOLD;
    logic      ready_hold = 1'b1;

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                RDY_TOGGLE: m_axis_tready = ~m_axis_tready;
                RDY_RANDOM: m_axis_tready = 1'($urandom_range(0, 1));
                default:    m_axis_tready = ready_hold;
            endcase
        end
    end

    // Monitor: collects accepted beats, counts frame_err pulses, checks stall stability.
    logic [7:0] got_q[$];
    int         err_cnt = 0;
    int         cyc = 0;
    int         rise_cyc = 0;
    int         start_cyc = 0;
    logic       prev_tvalid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_stall  = 1'b0;
            prev_tvalid = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_tvalid_held", m_axis_tvalid, 1'b1);
                check("stall_tdata_stable", m_axis_tdata, prev_data);
            end
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
            if (frame_err) err_cnt++;
            if (m_axis_tvalid && !prev_tvalid) rise_cyc = cyc;
            prev_stall  = m_axis_tvalid && !m_axis_tready;
            prev_tvalid = m_axis_tvalid;
            prev_data   = m_axis_tdata;
        end
    end

    // Reference model: a good frame yields its byte; while the consumer is stalled the
    // output buffer holds FIFO_DEPTH bytes and any further byte is lost and flags overflow.
    logic [7:0] mdl_q[$];
    logic       mdl_ovf = 1'b0;

    task automatic mdl_frame(input logic [7:0] d, input logic stalled);
        if (stalled && mdl_q.size() == FIFO_DEPTH) mdl_ovf = 1'b1;
        else mdl_q.push_back(d);
    endtask

    task automatic expect_beats(input string name);
        check({name, "_count"}, got_q.size(), mdl_q.size());
        for (int i = 0; i < got_q.size() && i < mdl_q.size(); i++)
            check($sformatf("%s_beat%0d", name, i), got_q[i], mdl_q[i]);
        got_q.delete();
        mdl_q.delete();
    endtask

    // Line driver; all tasks start and end 1 time unit after a rising edge.
    task automatic drive_half(input logic v);
        serial_in = v;
        repeat (HALF_BIT) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        serial_in = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // pos 0 is the start bit, pos 1..8 the data bits MSB first. A corrupted symbol is
    // sent and the line then goes idle; max_halves truncates the frame mid-flight.
    task automatic send_frame(input logic [7:0] d, input int bad_pos, input logic [1:0] bad_val,
                              input int max_halves);
        logic [1:0] sym;
        int         halves;
        halves    = 0;
        start_cyc = cyc;
        for (int p = 0; p < 9; p++) begin
            if (p == 0) sym = 2'b10;
            else        sym = d[8-p] ? 2'b01 : 2'b10;
            if (p == bad_pos) sym = bad_val;
            for (int h = 1; h >= 0; h--) begin
                if (halves == max_halves) return;
                drive_half(sym[h]);
                halves++;
            end
            if (p == bad_pos) break;
        end
        serial_in = 1'b0;
    endtask

    typedef struct {
        logic [7:0] data;
        int         bad_pos;
        logic [1:0] bad_val;
        int         exp_beats;
        int         exp_errs;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion required completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         e0;
        int         exp_errs;
        logic [7:0] d;
        logic       corrupt;
        int         pos;
        logic [1:0] val;
        logic       saw_busy;

        vecs[0] = '{8'hF0, -1, 2'b00, 1, 0};
        vecs[1] = '{8'h0F, -1, 2'b00, 1, 0};
        vecs[2] = '{8'hAA, -1, 2'b00, 1, 0};
        vecs[3] = '{8'hA5,  3, 2'b11, 0, 1};
        vecs[4] = '{8'h3C, -1, 2'b00, 1, 0};
        vecs[5] = '{8'h5A,  0, 2'b11, 0, 1};
        vecs[6] = '{8'hC3,  8, 2'b00, 0, 1};

        repeat (3) @(posedge aclk);
        #1;
        check("reset_tvalid", m_axis_tvalid, 1'b0);
        check("reset_tdata", m_axis_tdata, 8'h00);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_overflow", overflow, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        aresetn = 1'b1;
        idle(8);

        for (int i = 0; i < 7; i++) begin
            e0 = err_cnt;
            send_frame(vecs[i].data, vecs[i].bad_pos, vecs[i].bad_val, 18);
            idle(8);
            check($sformatf("vec%0d_errs", i), err_cnt - e0, vecs[i].exp_errs);
            check($sformatf("vec%0d_beats", i), got_q.size(), vecs[i].exp_beats);
            if (vecs[i].exp_beats > 0 && got_q.size() > 0)
                check($sformatf("vec%0d_data", i), got_q[0], vecs[i].data);
            if (i == 0) check("start_to_tvalid_latency", rise_cyc - start_cyc, LATENCY);
            got_q.delete();
        end

        // One-cycle glitch on an armed idle line: false start, no error, busy drops quickly.
        e0 = err_cnt;
        saw_busy = 1'b0;
        serial_in = 1'b1;
        @(posedge aclk);
        #1;
        serial_in = 1'b0;
        for (int i = 0; i < HALF_BIT + 2 + SYNC_LAT; i++) begin
            @(negedge aclk);
            saw_busy = saw_busy | rx_busy;
        end
        check("glitch_busy_seen", saw_busy, 1'b1);
        check("glitch_busy_dropped", rx_busy, 1'b0);
        @(posedge aclk);
        #1;
        idle(10);
        check("glitch_no_err", err_cnt - e0, 0);
        expect_beats("glitch");

        // Stalled consumer: five frames, only four fit.
        ready_hold = 1'b0;
        idle(2);
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), -1, 2'b00, 18);
            idle(8);
            mdl_frame(8'(i), 1'b1);
            check($sformatf("overflow_after_frame%0d", i), overflow, mdl_ovf);
        end
        check("stalled_head_tdata", m_axis_tdata, mdl_q[0]);
        ready_hold = 1'b1;
        idle(10);
        expect_beats("overflow_drain");
        check("overflow_sticky", overflow, 1'b1);

        // tready toggling every cycle over four queued bytes.
        ready_hold = 1'b0;
        idle(2);
        for (int i = 1; i <= 4; i++) begin
            d = 8'(i * 17);
            send_frame(d, -1, 2'b00, 18);
            idle(8);
            mdl_frame(d, 1'b1);
        end
        rdy_mode = RDY_TOGGLE;
        idle(20);
        rdy_mode = RDY_HOLD;
        ready_hold = 1'b1;
        idle(4);
        expect_beats("toggle");

        // Reset in the middle of bit 4 of frame 0x55 with a byte still queued.
        ready_hold = 1'b0;
        idle(2);
        send_frame(8'h77, -1, 2'b00, 18);
        idle(8);
        mdl_frame(8'h77, 1'b1);
        check("pre_reset_tvalid", m_axis_tvalid, 1'b1);
        check("pre_reset_tdata", m_axis_tdata, mdl_q[0]);
        send_frame(8'h55, -1, 2'b00, 9);
        check("pre_reset_busy", rx_busy, 1'b1);
        aresetn = 1'b0;
        #1;
        check("midframe_reset_tvalid", m_axis_tvalid, 1'b0);
        check("midframe_reset_tdata", m_axis_tdata, 8'h00);
        check("midframe_reset_frame_err", frame_err, 1'b0);
        check("midframe_reset_overflow", overflow, 1'b0);
        check("midframe_reset_busy", rx_busy, 1'b0);
        mdl_q.delete();
        got_q.delete();
        mdl_ovf = 1'b0;
        serial_in = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        aresetn = 1'b1;
        ready_hold = 1'b1;
        idle(8);
        send_frame(8'h99, -1, 2'b00, 18);
        idle(8);
        mdl_frame(8'h99, 1'b0);
        expect_beats("after_reset");
        check("after_reset_overflow", overflow, 1'b0);

        // Random frames, random corruption, random backpressure.
        rdy_mode = RDY_RANDOM;
        e0 = err_cnt;
        exp_errs = 0;
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            corrupt = ($urandom_range(0, 3) == 0);
            pos = $urandom_range(0, 8);
            val = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            if (corrupt) begin
                send_frame(d, pos, val, 18);
                // A start bit sent as 00 never raises the line, so nothing is seen at all.
                if (!(pos == 0 && val == 2'b00)) exp_errs++;
            end else begin
                send_frame(d, -1, 2'b00, 18);
                mdl_frame(d, 1'b0);
            end
            idle(8 + $urandom_range(0, 7));
        end
        rdy_mode = RDY_HOLD;
        ready_hold = 1'b1;
        idle(6);
        check("random_errs", err_cnt - e0, exp_errs);
        expect_beats("random");
        check("random_no_overflow", overflow, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
